// File: rtl/scan_coord_gen.sv
// Raster scan timing generator: (coord_x, coord_y) stream plus hsync/vsync/active and start flags.
// Optional frame counter output enabled by defining SCAN_COORD_FRAME_COUNT_EN.
module scan_coord_gen #(
  parameter int unsigned COORD_WIDTH     = 16,
  parameter int unsigned H_ACTIVE        = 640,
  parameter int unsigned H_FRONT         = 16,
  parameter int unsigned H_SYNC          = 96,
  parameter int unsigned H_BACK          = 48,
  parameter int unsigned V_ACTIVE        = 480,
  parameter int unsigned V_FRONT         = 10,
  parameter int unsigned V_SYNC          = 2,
  parameter int unsigned V_BACK          = 33,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pixel_en,
  output logic [COORD_WIDTH-1:0] coord_x,
  output logic [COORD_WIDTH-1:0] coord_y,
  output logic                   active,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   line_start,
  output logic                   frame_start,
`ifdef SCAN_COORD_FRAME_COUNT_EN
  output logic [15:0]            frame_count,
`endif
  output logic                   vblank_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_BEG  = H_ACTIVE + H_FRONT;
  localparam int unsigned HS_END  = H_ACTIVE + H_FRONT + H_SYNC;
  localparam int unsigned VS_BEG  = V_ACTIVE + V_FRONT;
  localparam int unsigned VS_END  = V_ACTIVE + V_FRONT + V_SYNC;
  localparam longint unsigned COORD_RANGE = 64'(1) << COORD_WIDTH;

  // Refuse to build when the counters cannot hold a full line or frame.
  if (COORD_WIDTH > 32) begin : g_cw_chk
    $error("scan_coord_gen: COORD_WIDTH must not exceed 32");
  end
  if (64'(H_TOTAL) > COORD_RANGE) begin : g_h_chk
    $error("scan_coord_gen: H_TOTAL does not fit in COORD_WIDTH");
  end
  if (64'(V_TOTAL) > COORD_RANGE) begin : g_v_chk
    $error("scan_coord_gen: V_TOTAL does not fit in COORD_WIDTH");
  end

  logic [COORD_WIDTH-1:0] x_q, x_d;
  logic [COORD_WIDTH-1:0] y_q, y_d;
  logic                   active_q, active_d;
  logic                   hsync_q, hsync_d;
  logic                   vsync_q, vsync_d;
  logic                   line_start_q, line_start_d;
  logic                   frame_start_q, frame_start_d;
  logic                   vblank_start_q, vblank_start_d;
  logic                   x_last, y_last;
  logic                   h_win, v_win;
`ifdef SCAN_COORD_FRAME_COUNT_EN
  logic [15:0]            frame_count_q, frame_count_d;
`endif

  // Next position, then every flag decoded from it so flags never lag the coordinates.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    x_last = (32'(x_q) == H_TOTAL - 1);
    y_last = (32'(y_q) == V_TOTAL - 1);
    if (pixel_en) begin
      if (x_last) begin
        x_d = '0;
        y_d = y_last ? '0 : y_q + COORD_WIDTH'(1);
      end else begin
        x_d = x_q + COORD_WIDTH'(1);
      end
    end
    h_win          = (32'(x_d) >= HS_BEG) && (32'(x_d) < HS_END);
    v_win          = (32'(y_d) >= VS_BEG) && (32'(y_d) < VS_END);
    active_d       = (32'(x_d) < H_ACTIVE) && (32'(y_d) < V_ACTIVE);
    hsync_d        = h_win ^ SYNC_ACTIVE_LOW;
    vsync_d        = v_win ^ SYNC_ACTIVE_LOW;
    line_start_d   = (x_d == '0);
    frame_start_d  = (x_d == '0) && (y_d == '0);
    vblank_start_d = (x_d == '0) && (32'(y_d) == V_ACTIVE);
  end

`ifdef SCAN_COORD_FRAME_COUNT_EN
  // Counts (last,last) -> (0,0) wraps; free-running modulo 2^16.
  always_comb begin
    frame_count_d = frame_count_q;
    if (pixel_en && x_last && y_last) begin
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count_q <= 16'd0;
    end else begin
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_count = frame_count_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q            <= '0;
      y_q            <= '0;
      active_q       <= 1'b1;
      hsync_q        <= SYNC_ACTIVE_LOW;
      vsync_q        <= SYNC_ACTIVE_LOW;
      line_start_q   <= 1'b1;
      frame_start_q  <= 1'b1;
      vblank_start_q <= 1'b0;
    end else begin
      x_q            <= x_d;
      y_q            <= y_d;
      active_q       <= active_d;
      hsync_q        <= hsync_d;
      vsync_q        <= vsync_d;
      line_start_q   <= line_start_d;
      frame_start_q  <= frame_start_d;
      vblank_start_q <= vblank_start_d;
    end
  end

  assign coord_x      = x_q;
  assign coord_y      = y_q;
  assign active       = active_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign line_start   = line_start_q;
  assign frame_start  = frame_start_q;
  assign vblank_start = vblank_start_q;

endmodule

// File: doc/scan_coord_gen.md
Name: scan_coord_gen

Overview:
- Raster scan timing generator for the GPU pixel path.
- Produces the (coord_x, coord_y) point stream that the rect collision comparators test against rect bounds.
- Produces the matching hsync/vsync/active timing for the display output.
- Sits between the pixel clock-enable source and the rect hit pipeline; it is the producer end of the coordinate interface the comparators consume.

Parameters:
- COORD_WIDTH, 16, width of coordinate and counter outputs; must hold H_TOTAL-1 and V_TOTAL-1.
- H_ACTIVE, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync pulse width in pixels.
- H_BACK, 48, horizontal back porch in pixels.
- V_ACTIVE, 480, visible lines per frame.
- V_FRONT, 10, vertical front porch in lines.
- V_SYNC, 2, vsync pulse width in lines.
- V_BACK, 33, vertical back porch in lines.
- SYNC_ACTIVE_LOW, 1, 1 means hsync/vsync are driven low during the sync pulse.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- pixel_en  input  1  pixel tick; counters advance only on clk edges where pixel_en=1.
- coord_x  output  COORD_WIDTH  current horizontal position, 0..H_TOTAL-1.
- coord_y  output  COORD_WIDTH  current vertical position, 0..V_TOTAL-1.
- active  output  1  1 when coord_x<H_ACTIVE and coord_y<V_ACTIVE.
- hsync  output  1  horizontal sync, polarity per SYNC_ACTIVE_LOW.
- vsync  output  1  vertical sync, polarity per SYNC_ACTIVE_LOW.
- line_start  output  1  1 for the pixel tick where coord_x==0.
- frame_start  output  1  1 for the pixel tick where coord_x==0 and coord_y==0.
- vblank_start  output  1  1 for the pixel tick where coord_x==0 and coord_y==V_ACTIVE.

Behaviour:
- Derived constants: H_TOTAL=H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL=V_ACTIVE+V_FRONT+V_SYNC+V_BACK (525).
- All outputs are registered and change only on clk edges.
- Reset (synchronous, takes priority over pixel_en):
  - coord_x=0, coord_y=0, active=1.
  - hsync and vsync deasserted (high when SYNC_ACTIVE_LOW=1).
  - line_start=1, frame_start=1, vblank_start=0.
  - i.e. all outputs reflect position (0,0).
- Pixel advance, on a clk edge with pixel_en=1 and reset=0:
  - If coord_x==H_TOTAL-1: coord_x wraps to 0 and coord_y advances.
  - coord_y advances by incrementing, or wraps to 0 when it equals V_TOTAL-1.
  - Otherwise coord_x increments.
- pixel_en=0: every output holds its value, including the pulse flags.
  - Pulse flags are qualified by position, not by a cycle count; a downstream consumer samples them together with pixel_en.
- Decoded outputs are registered from the next-state position, so they are always coherent with coord_x/coord_y in the same cycle (zero relative skew):
  - hsync is asserted when H_ACTIVE+H_FRONT <= coord_x < H_ACTIVE+H_FRONT+H_SYNC (656..751).
  - vsync is asserted when V_ACTIVE+V_FRONT <= coord_y < V_ACTIVE+V_FRONT+V_SYNC (490..491).
  - vsync changes only at coord_x==0.
- Boundary conditions:
  - Line wrap and frame wrap happen in the same tick at (H_TOTAL-1, V_TOTAL-1) -> (0,0), with frame_start=1 and line_start=1.
  - Reset asserted mid-line or mid-frame forces (0,0) on the next edge regardless of pixel_en.
  - pixel_en tied high gives one pixel per clk.
- Arithmetic:
  - Counter compares are against full-width constants; no out-of-range value is reachable.
  - Elaboration must fail if H_TOTAL or V_TOTAL exceeds 2^COORD_WIDTH.

Optional Feature:
- Macro: SCAN_COORD_FRAME_COUNT_EN.
- When defined, adds output port frame_count (16 bits):
  - reset value 0;
  - increments by 1 on each pixel tick that wraps (H_TOTAL-1, V_TOTAL-1) -> (0,0);
  - wraps 0xFFFF -> 0;
  - feeds animation/vsync-wait logic in the CPU.
- When not defined, the port and its register are absent and all other behaviour is identical.

Test Plan:
- Reset then pixel_en=1 for 800 clks -> coord_x steps 0..799 then 0; coord_y goes 0 -> 1 exactly at the wrap; line_start=1 at x=0 only.
- Full frame, pixel_en=1 for 420000 clks -> frame_start pulses once per frame; coord_y never exceeds 524; vblank_start asserts at (0,480) only.
- Sync windows with SYNC_ACTIVE_LOW=1 -> hsync low exactly for x=656..751 (96 ticks per line); vsync low exactly for y=490..491 (1600 ticks); active=0 for x>=640 or y>=480.
- pixel_en toggled 1,0,0,1 pattern -> outputs frozen on pixel_en=0 cycles; coord_x advances by 2 over 4 clks; no flag glitches.
- Reset asserted at (700,300) with pixel_en=0 -> next edge gives (0,0), active=1, frame_start=1, hsync/vsync high.
- With SCAN_COORD_FRAME_COUNT_EN -> frame_count=0 after reset, 3 after 3 full frames; preloaded to 0xFFFF via force, it wraps to 0 on the next frame wrap.
